// File: rtl/fpu_mul_norm_rnd_pipe.sv
// fpu_mul_norm_rnd_pipe
//   Two-stage normalise/round pipeline for a floating-point multiplier.
//   Stage A shifts the raw product (left to normalise, right to denormalise)
//   and extracts the mantissa field, guard bit and sticky bit.  Stage B
//   applies the rounding increment and presents the result with a
//   valid/ready handshake that holds the output stable while stalled.
//
//   Configuration macro: FPU_MUL_RND_MODE_EN
//     defined   -> in_rmode / in_sign select RN, RZ, RP or RM rounding
//     undefined -> in_rmode / in_sign are ignored and RN is always used
module fpu_mul_norm_rnd_pipe #(
  parameter int FRAC_W = 106,
  parameter int OUT_W  = 52,
  parameter int SH_W   = 7,
  parameter int TAG_W  = 4
) (
  input  logic               rclk,
  input  logic               arst_l,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [FRAC_W-1:0]  in_prod,
  input  logic [SH_W-1:0]    in_shamt,
  input  logic               in_shr,
  input  logic               in_sign,
  input  logic [1:0]         in_rmode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [OUT_W-1:0]   out_frac,
  output logic               out_hid,
  output logic               out_cout,
  output logic               out_nx,
  output logic               out_adj,
  output logic [TAG_W-1:0]   out_tag
);

  // Field is the stored fraction plus the hidden bit; the guard bit sits
  // directly below it and everything under the guard bit folds into sticky.
  localparam int FW = OUT_W + 1;
  localparam int GB = FRAC_W - FW - 1;

  // ---------------------------------------------------------------------
  // Stage A combinational: shift, one-bit normalise adjust, field extract
  // ---------------------------------------------------------------------
  logic [FRAC_W-1:0] w_s;
  logic [FRAC_W-1:0] w_mask;
  logic [FRAC_W-1:0] w_win;
  logic              w_shout;
  logic              w_adj;
  logic [FW-1:0]     w_f;
  logic              w_g;
  logic              w_st;

  // A shift count at or beyond the product width yields zero in both
  // directions, and the mask then covers the whole product so every bit
  // of a right-shifted product lands in sticky.
  assign w_s     = in_shr ? (in_prod >> in_shamt) : (in_prod << in_shamt);
  assign w_mask  = ~({FRAC_W{1'b1}} << in_shamt);
  assign w_shout = in_shr & (|(in_prod & w_mask));

  // A left-shifted product whose MSB is clear is one bit short of
  // normalised: slide the field window down by one bit.
  assign w_adj   = ~in_shr & ~w_s[FRAC_W-1];
  assign w_win   = w_adj ? {w_s[FRAC_W-2:0], 1'b0} : w_s;
  assign w_f     = w_win[FRAC_W-1 -: FW];
  assign w_g     = w_win[GB];
  assign w_st    = (|w_win[GB-1:0]) | w_shout;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic r_a_vld;
  logic r_b_vld;
  logic w_b_adv;

  assign w_b_adv = ~r_b_vld | out_rdy;
  assign in_rdy  = ~r_a_vld | w_b_adv;
  assign out_vld = r_b_vld;

  // ---------------------------------------------------------------------
  // Stage A registers
  // ---------------------------------------------------------------------
  logic [FW-1:0]    r_a_f;
  logic             r_a_g;
  logic             r_a_st;
  logic             r_a_adj;
  logic [TAG_W-1:0] r_a_tag;
`ifdef FPU_MUL_RND_MODE_EN
  logic             r_a_sign;
  logic [1:0]       r_a_rmode;
`else
  logic             w_unused_rnd;
  assign w_unused_rnd = ^{in_sign, in_rmode};
`endif

  // Stage A capture: load a new operation whenever the slot is free or draining
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_a_vld   <= 1'b0;
      r_a_f     <= '0;
      r_a_g     <= 1'b0;
      r_a_st    <= 1'b0;
      r_a_adj   <= 1'b0;
      r_a_tag   <= '0;
`ifdef FPU_MUL_RND_MODE_EN
      r_a_sign  <= 1'b0;
      r_a_rmode <= 2'd0;
`endif
    end else if (in_rdy) begin
      r_a_vld <= in_vld;
      if (in_vld) begin
        r_a_f     <= w_f;
        r_a_g     <= w_g;
        r_a_st    <= w_st;
        r_a_adj   <= w_adj;
        r_a_tag   <= in_tag;
`ifdef FPU_MUL_RND_MODE_EN
        r_a_sign  <= in_sign;
        r_a_rmode <= in_rmode;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage B combinational: rounding increment and add
  // ---------------------------------------------------------------------
  logic        w_inc;
  logic [FW:0] w_r;

  // Rounding decision from guard, sticky, LSB and (optionally) sign/mode
  always_comb begin
    w_inc = 1'b0;
`ifdef FPU_MUL_RND_MODE_EN
    case (r_a_rmode)
      2'd0:    w_inc = r_a_g & (r_a_st | r_a_f[0]);
      2'd1:    w_inc = 1'b0;
      2'd2:    w_inc = ~r_a_sign & (r_a_g | r_a_st);
      default: w_inc = r_a_sign & (r_a_g | r_a_st);
    endcase
`else
    w_inc = r_a_g & (r_a_st | r_a_f[0]);
`endif
  end

  assign w_r = {1'b0, r_a_f} + {{FW{1'b0}}, w_inc};

  // ---------------------------------------------------------------------
  // Stage B registers (these drive the outputs directly)
  // ---------------------------------------------------------------------
  logic [OUT_W-1:0] r_frac;
  logic             r_hid;
  logic             r_cout;
  logic             r_nx;
  logic             r_adj;
  logic [TAG_W-1:0] r_tag;

  // Stage B capture: only moves when the consumer has taken the current result
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_b_vld <= 1'b0;
      r_frac  <= '0;
      r_hid   <= 1'b0;
      r_cout  <= 1'b0;
      r_nx    <= 1'b0;
      r_adj   <= 1'b0;
      r_tag   <= '0;
    end else if (w_b_adv) begin
      r_b_vld <= r_a_vld;
      if (r_a_vld) begin
        r_frac <= w_r[OUT_W-1:0];
        r_hid  <= w_r[OUT_W];
        r_cout <= w_r[OUT_W+1];
        r_nx   <= r_a_g | r_a_st;
        r_adj  <= r_a_adj;
        r_tag  <= r_a_tag;
      end
    end
  end

  assign out_frac = r_frac;
  assign out_hid  = r_hid;
  assign out_cout = r_cout;
  assign out_nx   = r_nx;
  assign out_adj  = r_adj;
  assign out_tag  = r_tag;

endmodule

// File: tb/tb_fpu_mul_norm_rnd_pipe.sv
// Bench for fpu_mul_norm_rnd_pipe (default parameters).
// A value-level model predicts every result; a scoreboard compares each
// valid output cycle, and directed vectors pin the model with literals.
module tb_fpu_mul_norm_rnd_pipe;

  logic         rclk = 1'b0;
  logic         arst_l = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [105:0] in_prod = '0;
  logic [6:0]   in_shamt = '0;
  logic         in_shr = 1'b0;
  logic         in_sign = 1'b0;
  logic [1:0]   in_rmode = 2'd0;
  logic [3:0]   in_tag = '0;
  logic         out_vld;
  logic         out_rdy = 1'b1;
  logic [51:0]  out_frac;
  logic         out_hid;
  logic         out_cout;
  logic         out_nx;
  logic         out_adj;
  logic [3:0]   out_tag;

  always #5 rclk = ~rclk;

  fpu_mul_norm_rnd_pipe dut (
    .rclk(rclk), .arst_l(arst_l),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_prod(in_prod), .in_shamt(in_shamt), .in_shr(in_shr),
    .in_sign(in_sign), .in_rmode(in_rmode), .in_tag(in_tag),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_frac(out_frac), .out_hid(out_hid), .out_cout(out_cout),
    .out_nx(out_nx), .out_adj(out_adj), .out_tag(out_tag)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [59:0] exp_q[$];   // {tag, cout, hid, frac, nx, adj}
  int out_tags[$];
  int out_cycs[$];

  // Value-level model: treat the shifted product as a number, split it into
  // the kept part and the remainder, and decide rounding by comparing the
  // remainder against one half ULP.
  function automatic logic [55:0] model(input logic [105:0] prod, input int sh,
                                        input bit shr, input bit sign, input logic [1:0] rm);
    logic [105:0] s;
    logic [52:0]  f;
    logic [52:0]  rem;
    logic [52:0]  half;
    logic [53:0]  r;
    logic [1:0]   m;
    bit adj, lost, up, inexact;
    adj = 0; lost = 0; up = 0;
`ifdef FPU_MUL_RND_MODE_EN
    m = rm;
`else
    m = 2'd0;
`endif
    if (shr) begin
      s = (sh >= 106) ? '0 : (prod >> sh);
      for (int i = 0; i < 106; i++) if (i < sh && prod[i]) lost = 1;
    end else begin
      s = (sh >= 106) ? '0 : (prod << sh);
      if (!s[105]) begin s = s << 1; adj = 1; end
    end
    f    = s[105:53];
    rem  = s[52:0];
    half = 53'd1 << 52;
    inexact = (rem != 0) || lost;
    case (m)
      2'd0:    up = (rem > half) || (rem == half && (lost || f[0]));
      2'd1:    up = 0;
      2'd2:    up = inexact && !sign;
      default: up = inexact && sign;
    endcase
    r = {1'b0, f} + 54'(up);
    return {r[53], r[52], r[51:0], inexact, adj};
  endfunction

  function automatic logic [55:0] lit(input bit c, input bit h, input logic [51:0] fr,
                                      input bit nx, input bit adj);
    return {c, h, fr, nx, adj};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Scoreboard bookkeeping on the active edge: retire taken results, enqueue accepts
  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (!arst_l) exp_q.delete();
    else begin
      if (out_vld && out_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_vld && in_rdy)
        exp_q.push_back({in_tag, model(in_prod, int'(in_shamt), in_shr, in_sign, in_rmode)});
    end
  end

  // Compare process: every valid output cycle must match the head of the queue
  always @(negedge rclk) begin
    if (arst_l && out_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got tag %0d with nothing expected", out_tag);
      end else if ({out_tag, out_cout, out_hid, out_frac, out_nx, out_adj} !== exp_q[0]) begin
        errors++;
        $display("FAIL sb_result: got %h expected %h",
                 {out_tag, out_cout, out_hid, out_frac, out_nx, out_adj}, exp_q[0]);
      end
      if (out_rdy) begin
        out_tags.push_back(int'(out_tag));
        out_cycs.push_back(cyc);
        $display("txn tag=%0d cout=%0d hid=%0d frac=%h nx=%0d adj=%0d",
                 out_tag, out_cout, out_hid, out_frac, out_nx, out_adj);
      end
    end
  end

  task automatic drive(input logic [105:0] p, input logic [6:0] sh, input bit shr,
                       input bit sg, input logic [1:0] rm, input logic [3:0] tg);
    in_prod = p; in_shamt = sh; in_shr = shr; in_sign = sg; in_rmode = rm; in_tag = tg;
  endtask

  // One isolated operation: pin the model, check latency and literal result
  task automatic run_vec(input string name, input logic [105:0] p, input logic [6:0] sh,
                         input bit shr, input bit sg, input logic [1:0] rm,
                         input logic [55:0] expv);
    int n;
    chk({name, "_model"}, 64'(model(p, int'(sh), shr, sg, rm)), 64'(expv));
    @(posedge rclk); #1;
    drive(p, sh, shr, sg, rm, 4'hA);
    in_vld = 1'b1;
    @(posedge rclk); #1;
    in_vld = 1'b0;
    n = 0;
    do begin @(negedge rclk); n++; end while (!out_vld && n < 10);
    chk({name, "_lat"}, 64'(n), 64'd2);
    chk({name, "_res"}, 64'({out_cout, out_hid, out_frac, out_nx, out_adj}), 64'(expv));
  endtask

  // Offer consecutive tags; counts how many were accepted within ncyc cycles
  task automatic offer(input int first, input int last, input int ncyc, output int acc);
    int t;
    bit rdy;
    t = first; acc = 0;
    @(posedge rclk); #1;
    drive('1, 7'd0, 1'b0, 1'b0, 2'd0, 4'(t));
    in_vld = 1'b1;
    for (int c = 0; c < ncyc && in_vld; c++) begin
      @(negedge rclk); rdy = in_rdy;
      @(posedge rclk); #1;
      if (rdy) begin
        acc++; t++;
        if (t > last) in_vld = 1'b0;
        else in_tag = 4'(t);
      end
    end
  endtask

  logic [105:0] p;
  logic [105:0] p2;
  int acc;
  bit rdy;
  bit ok;

  initial begin
    // Reset state
    arst_l = 1'b0;
    repeat (2) @(negedge rclk);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_outputs", 64'({out_cout, out_hid, out_frac, out_nx, out_adj, out_tag}), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge rclk); #1 arst_l = 1'b1;
    @(negedge rclk);
    chk("rel_in_rdy", 64'(in_rdy), 64'd1);

    // Directed vectors with literal expectations
    p = '0; p[105] = 1'b1;
    run_vec("v_unit", p, 7'd0, 1'b0, 1'b0, 2'd0, lit(0, 1, 52'd0, 0, 0));
    p2 = '0; p2[105] = 1'b1; p2[53] = 1'b1; p2[52] = 1'b1;
    run_vec("v_rn_up", p2, 7'd0, 1'b0, 1'b0, 2'd0, lit(0, 1, 52'd2, 1, 0));
`ifdef FPU_MUL_RND_MODE_EN
    run_vec("v_rz", p2, 7'd0, 1'b0, 1'b0, 2'd1, lit(0, 1, 52'd1, 1, 0));
    run_vec("v_rp_neg", p2, 7'd0, 1'b0, 1'b1, 2'd2, lit(0, 1, 52'd1, 1, 0));
`else
    run_vec("v_rz", p2, 7'd0, 1'b0, 1'b0, 2'd1, lit(0, 1, 52'd2, 1, 0));
    run_vec("v_rp_neg", p2, 7'd0, 1'b0, 1'b1, 2'd2, lit(0, 1, 52'd2, 1, 0));
`endif
    run_vec("v_rm_neg", p2, 7'd0, 1'b0, 1'b1, 2'd3, lit(0, 1, 52'd2, 1, 0));
    p = '0; p[105] = 1'b1; p[52] = 1'b1;
    run_vec("v_tie_even", p, 7'd0, 1'b0, 1'b0, 2'd0, lit(0, 1, 52'd0, 1, 0));
    p = '0; p[104] = 1'b1;
    run_vec("v_adj", p, 7'd0, 1'b0, 1'b0, 2'd0, lit(0, 1, 52'd0, 0, 1));
    p = '0; p[50] = 1'b1;
    run_vec("v_shl55", p, 7'd55, 1'b0, 1'b0, 2'd0, lit(0, 1, 52'd0, 0, 0));
    run_vec("v_shl54", p, 7'd54, 1'b0, 1'b0, 2'd0, lit(0, 1, 52'd0, 0, 1));
    run_vec("v_shl_big", p, 7'd110, 1'b0, 1'b0, 2'd0, lit(0, 0, 52'd0, 0, 1));
    p = '0; p[105] = 1'b1; p[0] = 1'b1;
    run_vec("v_shr2", p, 7'd2, 1'b1, 1'b0, 2'd0, lit(0, 0, 52'd1 << 50, 1, 0));
    run_vec("v_shr127", p, 7'd127, 1'b1, 1'b0, 2'd0, lit(0, 0, 52'd0, 1, 0));
    p = '0; p[105] = 1'b1;
    run_vec("v_shr106", p, 7'd106, 1'b1, 1'b0, 2'd0, lit(0, 0, 52'd0, 1, 0));
    p = '1;
    run_vec("v_ones_rp", p, 7'd0, 1'b0, 1'b0, 2'd2, lit(1, 0, 52'd0, 1, 0));
`ifdef FPU_MUL_RND_MODE_EN
    run_vec("v_ones_rm", p, 7'd0, 1'b0, 1'b0, 2'd3, lit(0, 1, {52{1'b1}}, 1, 0));
`else
    run_vec("v_ones_rm", p, 7'd0, 1'b0, 1'b0, 2'd3, lit(1, 0, 52'd0, 1, 0));
`endif

    // Stall: out_rdy low, tags 1..3 offered back to back
    @(posedge rclk); #1 out_rdy = 1'b0;
    out_tags.delete(); out_cycs.delete();
    offer(1, 3, 4, acc);
    chk("stall_accepts", 64'(acc), 64'd2);
    @(negedge rclk);
    chk("stall_in_rdy", 64'(in_rdy), 64'd0);
    chk("stall_out_tag", 64'(out_tag), 64'd1);
    // Release: tag 3 still offered and must follow 1 and 2
    @(posedge rclk); #1 out_rdy = 1'b1;
    for (int c = 0; c < 10 && in_vld; c++) begin
      @(negedge rclk); rdy = in_rdy;
      @(posedge rclk); #1;
      if (rdy) in_vld = 1'b0;
    end
    repeat (5) @(negedge rclk);
    chk("order_count", 64'(out_tags.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("order_tag%0d", i), 64'((i < out_tags.size()) ? out_tags[i] : -1), 64'(i + 1));
    chk("order_back2back", 64'((out_cycs.size() == 3) ? out_cycs[2] - out_cycs[0] : -1), 64'd2);

    // Reset mid-stall discards in-flight operations
    @(posedge rclk); #1 out_rdy = 1'b0;
    offer(4, 5, 4, acc);
    chk("rst2_accepts", 64'(acc), 64'd2);
    @(negedge rclk); #2 arst_l = 1'b0;
    #1;
    chk("rst2_out_vld", 64'(out_vld), 64'd0);
    chk("rst2_outputs", 64'({out_cout, out_hid, out_frac, out_nx, out_adj, out_tag}), 64'd0);
    @(posedge rclk); #1 arst_l = 1'b1; out_rdy = 1'b1;
    @(negedge rclk);
    chk("rst2_in_rdy", 64'(in_rdy), 64'd1);
    ok = 1;
    repeat (3) begin @(negedge rclk); if (out_vld) ok = 0; end
    chk("rst2_empty", 64'(ok), 64'd1);

    // Streaming traffic with random backpressure, checked by the scoreboard
    for (int k = 0; k < 40; k++) begin
      drive({$urandom, $urandom, $urandom, $urandom},
            (k % 2 == 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 4'(k));
      in_vld = 1'b1;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge rclk); rdy = in_rdy;
        @(posedge rclk); #1;
        out_rdy = 1'($urandom_range(0, 1));
        if (rdy) ok = 1;
      end
      if (!ok) chk("stream_accept_timeout", 64'd0, 64'd1);
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    repeat (6) @(negedge rclk);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
